tug_round_sequencer: RTL and testbench

Game sequencer for the Tug-of-War board. It drives the 3-bit LED-mux select code, the one-hot rope-position score word, and the foul (fake-round) pattern. It steps through show-reset, ready, random dark delay, play window, foul display and win. The LED mux consumes `led_control`, `score` and `fake_score` directly; buttons arrive debounced as single-cycle pulses.

---
 rtl/tug_round_sequencer.sv | 129 ++++++++++++
 tb/tb_tug_round_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/tug_round_sequencer.sv
// Tug-of-War round sequencer: walks show-reset, ready, random dark delay, play,
// foul and win phases, driving the LED mux select, rope position and foul pattern.
module tug_round_sequencer #(
    parameter int unsigned RESET_TICKS = 2,
    parameter int unsigned READY_TICKS = 2,
    parameter int unsigned DELAY_MIN   = 2,
    parameter int unsigned PLAY_TICKS  = 8,
    parameter int unsigned FOUL_TICKS  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       btn_l,
    input  logic       btn_r,
    output logic [2:0] led_control,
    output logic [6:0] score,
    output logic [6:0] fake_score,
    output logic       win_l,
    output logic       win_r
);

    typedef enum logic [2:0] {
        S_SHOW_RST,
        S_READY,
        S_DARK,
        S_PLAY,
        S_FOUL,
        S_WIN
    } state_t;

    state_t     state, state_d;
    logic [7:0] cnt, cnt_d, cnt_inc;
    logic [7:0] delay;
    logic [7:0] lfsr;
    logic       lfsr_fb;
    logic [2:0] pos, pos_d;
    logic [6:0] fake_d;
    logic       win_l_d, win_r_d;
    logic [2:0] led_d;
    logic       press;

    assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    assign press   = btn_l | btn_r;
    assign cnt_inc = cnt + 8'd1;

    always_comb begin
        state_d = state;
        pos_d   = pos;
        fake_d  = fake_score;
        win_l_d = win_l;
        win_r_d = win_r;
        case (state)
            S_SHOW_RST: if (tick && cnt_inc == 8'(RESET_TICKS)) state_d = S_READY;
            S_READY:    if (tick && cnt_inc == 8'(READY_TICKS)) state_d = S_DARK;
            S_DARK: begin
                // an early press wins over the delay expiring in the same cycle
                if (press) begin
                    state_d = S_FOUL;
                    fake_d  = {btn_l, 5'b00000, btn_r};
                end else if (tick && cnt_inc == delay) begin
                    state_d = S_PLAY;
                end
            end
            S_PLAY: begin
                if (btn_l ^ btn_r) begin
                    pos_d = btn_l ? pos + 3'd1 : pos - 3'd1;
                    if (pos_d == 3'd6) begin
                        state_d = S_WIN;
                        win_l_d = 1'b1;
                    end else if (pos_d == 3'd0) begin
                        state_d = S_WIN;
                        win_r_d = 1'b1;
                    end else begin
                        state_d = S_DARK;
                    end
                end else if (btn_l & btn_r) begin
                    state_d = S_DARK;
                end else if (tick && cnt_inc == 8'(PLAY_TICKS)) begin
                    state_d = S_DARK;
                end
            end
            S_FOUL: begin
                if (tick && cnt_inc == 8'(FOUL_TICKS)) begin
                    state_d = S_DARK;
                    fake_d  = '0;
                end
            end
            default: ;
        endcase

        cnt_d = (state_d != state) ? '0 : (tick ? cnt_inc : cnt);

        case (state_d)
            S_SHOW_RST: led_d = 3'b001;
            S_READY:    led_d = 3'b010;
            S_DARK:     led_d = 3'b000;
            S_FOUL:     led_d = 3'b100;
            default:    led_d = 3'b011;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_SHOW_RST;
            cnt         <= '0;
            pos         <= 3'd3;
            score       <= 7'b0001000;
            fake_score  <= '0;
            win_l       <= 1'b0;
            win_r       <= 1'b0;
            led_control <= 3'b001;
            lfsr        <= 8'hA5;
            delay       <= 8'(DELAY_MIN);
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            pos         <= pos_d;
            score       <= 7'b0000001 << pos_d;
            fake_score  <= fake_d;
            win_l       <= win_l_d;
            win_r       <= win_r_d;
            led_control <= led_d;
            lfsr        <= {lfsr[6:0], lfsr_fb};
            if (state_d == S_DARK && state != S_DARK)
                delay <= 8'(DELAY_MIN) + {5'b00000, lfsr[2:0]};
        end
    end

endmodule

// File: tb/tb_tug_round_sequencer.sv
// Self-checking bench for tug_round_sequencer: countdown-based reference model
// compared every cycle, plus directed scenarios pinned with literal expectations.
module tb_tug_round_sequencer;

    localparam int RESET_TICKS = 2;
    localparam int READY_TICKS = 2;
    localparam int DELAY_MIN   = 2;
    localparam int PLAY_TICKS  = 8;
    localparam int FOUL_TICKS  = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic       btn_l = 1'b0;
    logic       btn_r = 1'b0;
    logic [2:0] led_control;
    logic [6:0] score;
    logic [6:0] fake_score;
    logic       win_l;
    logic       win_r;

    int tests = 0;
    int fails = 0;

    tug_round_sequencer #(
        .RESET_TICKS(RESET_TICKS),
        .READY_TICKS(READY_TICKS),
        .DELAY_MIN(DELAY_MIN),
        .PLAY_TICKS(PLAY_TICKS),
        .FOUL_TICKS(FOUL_TICKS)
    ) dut (
        .clk(clk),
        .reset(reset),
        .tick(tick),
        .btn_l(btn_l),
        .btn_r(btn_r),
        .led_control(led_control),
        .score(score),
        .fake_score(fake_score),
        .win_l(win_l),
        .win_r(win_r)
    );

    always #5 clk = ~clk;

    // Reference model: the displayed code plus ticks left before it changes.
    bit       m_valid = 0;
    int       m_led;
    int       m_left;
    int       m_pos;
    int       m_fake;
    bit       m_wl, m_wr;
    bit [7:0] m_lfsr;

    function automatic bit [7:0] lfsr_next(input bit [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_valid = 1;
            m_led = 1; m_left = RESET_TICKS; m_pos = 3; m_fake = 0;
            m_wl = 0; m_wr = 0; m_lfsr = 8'hA5;
        end else if (m_valid) begin
            bit go_dark;
            go_dark = 0;
            case (m_led)
                1: if (tick) begin
                    m_left--;
                    if (m_left == 0) begin m_led = 2; m_left = READY_TICKS; end
                end
                2: if (tick) begin
                    m_left--;
                    if (m_left == 0) go_dark = 1;
                end
                0: begin
                    if (btn_l || btn_r) begin
                        m_led = 4; m_left = FOUL_TICKS;
                        m_fake = (btn_l ? 64 : 0) + (btn_r ? 1 : 0);
                    end else if (tick) begin
                        m_left--;
                        if (m_left == 0) begin m_led = 3; m_left = PLAY_TICKS; end
                    end
                end
                3: if (!(m_wl || m_wr)) begin
                    if (btn_l != btn_r) begin
                        m_pos += btn_l ? 1 : -1;
                        if (m_pos == 6) m_wl = 1;
                        else if (m_pos == 0) m_wr = 1;
                        else go_dark = 1;
                    end else if (btn_l && btn_r) begin
                        go_dark = 1;
                    end else if (tick) begin
                        m_left--;
                        if (m_left == 0) go_dark = 1;
                    end
                end
                4: if (tick) begin
                    m_left--;
                    if (m_left == 0) begin m_fake = 0; go_dark = 1; end
                end
                default: ;
            endcase
            if (go_dark) begin
                m_led = 0;
                m_left = DELAY_MIN + int'(m_lfsr & 8'd7);
            end
            m_lfsr = lfsr_next(m_lfsr);
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            tests++;
            if (led_control !== 3'(m_led) || score !== 7'(1 << m_pos) ||
                fake_score !== 7'(m_fake) || win_l !== m_wl || win_r !== m_wr) begin
                fails++;
                $display("FAIL model_cmp t=%0t: got led=%b score=%b fake=%b wl=%b wr=%b, expected led=%b score=%b fake=%b wl=%b wr=%b",
                         $time, led_control, score, fake_score, win_l, win_r,
                         3'(m_led), 7'(1 << m_pos), 7'(m_fake), m_wl, m_wr);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic t, input logic l, input logic r, input logic rs);
        tick = t; btn_l = l; btn_r = r; reset = rs;
        @(posedge clk);
        #1;
        tick = 0; btn_l = 0; btn_r = 0; reset = 0;
    endtask

    task automatic wait_led(input logic [2:0] code, input string name);
        int n;
        n = 0;
        while (led_control !== code && n < 400) begin
            drive((n % 4) == 3, 1'b0, 1'b0, 1'b0);
            n++;
        end
        tests++;
        if (led_control !== code) begin
            fails++;
            $display("FAIL %s: timeout, led=%b expected %b", name, led_control, code);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        drive(0, 0, 0, 1);
        check("rst_led", 32'(led_control), 32'h1);
        check("rst_score", 32'(score), 32'h08);
        check("rst_fake", 32'(fake_score), 32'h0);
        check("rst_win", 32'({win_l, win_r}), 32'h0);

        // Run to the first play window, then walk the rope left to a win.
        wait_led(3'b011, "first_play");
        check("play_score", 32'(score), 32'h08);
        drive(0, 1, 0, 0);
        check("move_l1_score", 32'(score), 32'h10);
        check("move_l1_led", 32'(led_control), 32'h0);
        wait_led(3'b011, "play2");
        drive(0, 1, 0, 0);
        check("move_l2_score", 32'(score), 32'h20);
        wait_led(3'b011, "play3");
        drive(0, 1, 0, 0);
        check("win_score", 32'(score), 32'h40);
        check("win_l", 32'(win_l), 32'h1);
        check("win_led", 32'(led_control), 32'h3);
        for (int i = 0; i < 12; i++) drive(1, i[0], ~i[0], 0);
        check("win_hold_score", 32'(score), 32'h40);
        check("win_hold_led", 32'(led_control), 32'h3);
        check("win_hold_flags", 32'({win_l, win_r}), 32'h2);

        // Fouls during the dark delay.
        drive(0, 0, 0, 1);
        wait_led(3'b000, "dark1");
        drive(0, 0, 1, 0);
        check("foul_r_led", 32'(led_control), 32'h4);
        check("foul_r_fake", 32'(fake_score), 32'h01);
        wait_led(3'b000, "foul_exit");
        check("foul_exit_fake", 32'(fake_score), 32'h0);
        check("foul_exit_score", 32'(score), 32'h08);
        drive(0, 1, 1, 0);
        check("foul_both_fake", 32'(fake_score), 32'h41);
        wait_led(3'b000, "foul2_exit");

        // Simultaneous press in play: no move.
        wait_led(3'b011, "play_sim");
        drive(0, 1, 1, 0);
        check("sim_score", 32'(score), 32'h08);
        check("sim_led", 32'(led_control), 32'h0);

        // Timeout with no press, then press on the final tick.
        wait_led(3'b011, "play_to");
        for (int i = 0; i < PLAY_TICKS - 1; i++) drive(1, 0, 0, 0);
        check("to_still_play", 32'(led_control), 32'h3);
        drive(1, 0, 0, 0);
        check("to_led", 32'(led_control), 32'h0);
        check("to_score", 32'(score), 32'h08);
        wait_led(3'b011, "play_edge");
        for (int i = 0; i < PLAY_TICKS - 1; i++) drive(1, 0, 0, 0);
        drive(1, 0, 1, 0);
        check("edge_move_score", 32'(score), 32'h04);
        check("edge_move_led", 32'(led_control), 32'h0);

        // Drive to pos 1, then reset mid-play.
        wait_led(3'b011, "play_r");
        drive(0, 0, 1, 0);
        check("pos1_score", 32'(score), 32'h02);
        wait_led(3'b011, "play_rst");
        drive(0, 0, 0, 1);
        check("midrst_led", 32'(led_control), 32'h1);
        check("midrst_score", 32'(score), 32'h08);
        check("midrst_win", 32'({win_l, win_r}), 32'h0);

        // Randomized traffic against the model.
        for (int i = 0; i < 20000; i++) begin
            drive($urandom_range(0, 2) == 0, $urandom_range(0, 11) == 0,
                  $urandom_range(0, 11) == 0, $urandom_range(0, 599) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
